// File: rtl/stream_src_if.sv
// Valid/ready beat channel between a stimulus source and the block under test.
// Master drives data/valid/last; slave returns ready.
interface stream_src_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] data_o;
  logic             vld_o;
  logic             last_o;
  logic             rdy_i;

  modport master (
    output data_o,
    output vld_o,
    output last_o,
    input  rdy_i
  );

  modport slave (
    input  data_o,
    input  vld_o,
    input  last_o,
    output rdy_i
  );
endinterface

// File: rtl/stream_src_gen.sv
// Bounded-burst valid/ready source with data patterns and idle gaps.
// Define STREAM_SRC_RAND_GAP_EN to add an LFSR-randomised gap length.
module stream_src_gen #(
  parameter int          WIDTH = 32,
  parameter int          CNT_W = 16,
  parameter int          GAP_W = 4,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   base,
  input  logic [WIDTH-1:0]   step,
  input  logic [CNT_W-1:0]   n_beats,
  input  logic [GAP_W-1:0]   gap_len,
  input  logic               rand_en,
  stream_src_if.master       m,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q, vld_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic             hs;
  logic             is_last;
  logic [CNT_W-1:0] cnt_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic [GAP_W-1:0] gap_eff;

`ifdef STREAM_SRC_RAND_GAP_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        rnd_q, rnd_d;
  logic        fb;

  assign fb      = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign lfsr_d  = hs ? {fb, lfsr_q[15:1]} : lfsr_q;
  assign rnd_d   = (state_q == IDLE && start) ? rand_en : rnd_q;
  // Gap uses the LFSR value from before this handshake's advance.
  assign gap_eff = rnd_q ? (lfsr_q[GAP_W-1:0] & gap_q) : gap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
      rnd_q  <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      rnd_q  <= rnd_d;
    end
  end
`else
  logic unused_rand;
  assign unused_rand = ^{rand_en, SEED};
  assign gap_eff     = gap_q;
`endif

  assign hs      = vld_q & m.rdy_i;
  assign is_last = (beat_cnt_q == n_q - CNT_W'(1));
  assign cnt_nxt = beat_cnt_q + CNT_W'(1);

  always_comb begin
    data_nxt = data_q;
    unique case (mode_q)
      2'd0: data_nxt = data_q + step_q;
      2'd1: data_nxt = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
      2'd2: data_nxt = data_q;
      2'd3: data_nxt = data_q - step_q;
      default: data_nxt = data_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    vld_d      = vld_q;
    last_d     = last_q;
    done_d     = 1'b0;
    beat_cnt_d = beat_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    mode_d     = mode_q;
    step_d     = step_q;
    n_d        = n_q;
    gap_d      = gap_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d     = mode;
          step_d     = step;
          n_d        = n_beats;
          gap_d      = gap_len;
          beat_cnt_d = '0;
          data_d     = base;
          if (n_beats == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = SEND;
            vld_d   = 1'b1;
            last_d  = (n_beats == CNT_W'(1));
          end
        end
      end
      SEND: begin
        if (hs) begin
          beat_cnt_d = cnt_nxt;
          data_d     = data_nxt;
          if (is_last) begin
            state_d = IDLE;
            vld_d   = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else if (gap_eff != '0) begin
            state_d   = GAP;
            gap_cnt_d = gap_eff;
            vld_d     = 1'b0;
            last_d    = 1'b0;
          end else begin
            last_d = (cnt_nxt == n_q - CNT_W'(1));
          end
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q - GAP_W'(1);
        if (gap_cnt_q == GAP_W'(1)) begin
          state_d = SEND;
          vld_d   = 1'b1;
          last_d  = is_last;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      data_q     <= '0;
      vld_q      <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      beat_cnt_q <= '0;
      gap_cnt_q  <= '0;
      mode_q     <= '0;
      step_q     <= '0;
      n_q        <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      vld_q      <= vld_d;
      last_q     <= last_d;
      done_q     <= done_d;
      beat_cnt_q <= beat_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      mode_q     <= mode_d;
      step_q     <= step_d;
      n_q        <= n_d;
      gap_q      <= gap_d;
    end
  end

  assign m.data_o = data_q;
  assign m.vld_o  = vld_q;
  assign m.last_o = last_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_stream_src_gen.sv
// Scoreboard bench for stream_src_gen: stimulus queues expected beats,
// a monitor pops and compares data, last flag and arrival cycle.
module tb_stream_src_gen;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   mode = '0;
  logic [W-1:0] base = '0;
  logic [W-1:0] step = '0;
  logic [15:0]  n_beats = '0;
  logic [3:0]   gap_len = '0;
  logic         rand_en = 1'b0;
  logic         busy;
  logic         done;

  stream_src_if #(.WIDTH(W)) sif ();

  stream_src_gen #(
    .WIDTH(W),
    .CNT_W(16),
    .GAP_W(4),
    .SEED (16'hACE1)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .mode   (mode),
    .base   (base),
    .step   (step),
    .n_beats(n_beats),
    .gap_len(gap_len),
    .rand_en(rand_en),
    .m      (sif),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
    int           c;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int stall_cycles = 0;

  logic         stall = 1'b0;
  logic [W-1:0] pd = '0;
  logic         pl = 1'b0;
  exp_t         e;
  logic [15:0]  lf;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  task automatic push(input logic [W-1:0] d, input logic l, input int c);
    exp_t x;
    x.d = d;
    x.l = l;
    x.c = c;
    exp_q.push_back(x);
  endtask

  task automatic go(input logic [1:0] md, input logic [W-1:0] b,
                    input logic [W-1:0] s, input logic [15:0] n,
                    input logic [3:0] g, input logic r, output int c0);
    @(negedge clk);
    mode    = md;
    base    = b;
    step    = s;
    n_beats = n;
    gap_len = g;
    rand_en = r;
    start   = 1'b1;
    c0      = cyc;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int bound);
    int d0;
    bit seen;
    d0   = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done_cnt != d0) begin
        seen = 1'b1;
        break;
      end
    end
    chk({nm, "_done_seen"}, seen, 1'b1);
  endtask

  // Monitor samples just before each rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        stall = 1'b0;
        continue;
      end
      if (stall) begin
        chk("hold_vld", sif.vld_o, 1'b1);
        chk("hold_data", sif.data_o, pd);
        chk("hold_last", sif.last_o, pl);
      end
      if (sif.vld_o && sif.rdy_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0h, none expected",
                   sif.data_o);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", sif.data_o, e.d);
          chk("beat_last", sif.last_o, e.l);
          if (e.c >= 0) chk("beat_cycle", cyc, e.c);
        end
      end
      if (sif.vld_o && !sif.rdy_i) stall_cycles++;
      stall = sif.vld_o && !sif.rdy_i;
      pd    = sif.data_o;
      pl    = sif.last_o;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    int  c0;
    int  c;
    int  lastc;
    int  d0;
    int  g;
    bit  found;
    logic [W-1:0] v;

    sif.rdy_i = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_vld", sif.vld_o, 1'b0);
    chk("rst_data", sif.data_o, 8'h00);
    chk("rst_last", sif.last_o, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // mode 0 back-to-back
    go(2'd0, 8'd5, 8'd3, 16'd4, 4'd0, 1'b0, c0);
    chk("t1_busy", busy, 1'b1);
    push(8'd5, 1'b0, c0 + 1);
    push(8'd8, 1'b0, c0 + 2);
    push(8'd11, 1'b0, c0 + 3);
    push(8'd14, 1'b1, c0 + 4);
    wait_done("t1", 20);
    chk("t1_done_cyc", done_cyc, c0 + 5);
    chk("t1_busy_end", busy, 1'b0);

    // fixed gap of 2
    go(2'd0, 8'd0, 8'd1, 16'd3, 4'd2, 1'b0, c0);
    push(8'd0, 1'b0, c0 + 1);
    push(8'd1, 1'b0, c0 + 4);
    push(8'd2, 1'b1, c0 + 7);
    wait_done("t2", 30);
    chk("t2_done_cyc", done_cyc, c0 + 8);

    // walking bit with a 5-cycle stall on beat 2, then wrap
    go(2'd1, 8'd1, 8'd0, 16'd9, 4'd0, 1'b0, c0);
    v = 8'h01;
    for (int k = 0; k < 9; k++) begin
      push(v, k == 8, -1);
      v = {v[W-2:0], v[W-1]};
    end
    stall_cycles = 0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sif.vld_o && sif.data_o == 8'h02) begin
        found = 1'b1;
        break;
      end
    end
    chk("t3_found_beat2", found, 1'b1);
    sif.rdy_i = 1'b0;
    repeat (5) @(negedge clk);
    sif.rdy_i = 1'b1;
    wait_done("t3", 40);
    chk("t3_stall_cycles", stall_cycles, 5);

    // zero-beat burst
    d0 = done_cnt;
    go(2'd0, 8'd9, 8'd1, 16'd0, 4'd0, 1'b0, c0);
    chk("t4_busy", busy, 1'b0);
    @(negedge clk);
    chk("t4_done_cnt", done_cnt, d0 + 1);
    chk("t4_done_cyc", done_cyc, c0 + 1);

    // start while busy is ignored
    go(2'd0, 8'h20, 8'd1, 16'd3, 4'd2, 1'b0, c0);
    push(8'h20, 1'b0, c0 + 1);
    push(8'h21, 1'b0, c0 + 4);
    push(8'h22, 1'b1, c0 + 7);
    d0 = done_cnt;
    @(negedge clk);
    mode    = 2'd2;
    base    = 8'h55;
    n_beats = 16'd5;
    gap_len = 4'd0;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    wait_done("t4b", 30);
    repeat (10) @(negedge clk);
    chk("t4b_done_cnt", done_cnt, d0 + 1);
    chk("t4b_queue_empty", exp_q.size(), 0);

    // async reset mid-burst
    go(2'd0, 8'd10, 8'd1, 16'd6, 4'd0, 1'b0, c0);
    push(8'd10, 1'b0, c0 + 1);
    push(8'd11, 1'b0, c0 + 2);
    @(negedge clk);
    @(negedge clk);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("t5_vld", sif.vld_o, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_data", sif.data_o, 8'h00);
    chk("t5_last", sif.last_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_no_done", done_cnt, d0);
    chk("t5_queue_empty", exp_q.size(), 0);
    go(2'd0, 8'd10, 8'd1, 16'd6, 4'd0, 1'b0, c0);
    for (int k = 0; k < 6; k++) push(8'(10 + k), k == 5, c0 + 1 + k);
    wait_done("t5b", 20);
    chk("t5b_done_cyc", done_cyc, c0 + 7);

    // randomised gap (fixed 15 when the feature is compiled out)
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    go(2'd0, 8'd0, 8'd1, 16'd4, 4'hF, 1'b1, c0);
    lf = 16'hACE1;
    c  = c0 + 1;
    lastc = c;
    for (int k = 0; k < 4; k++) begin
      push(8'(k), k == 3, c);
      lastc = c;
`ifdef STREAM_SRC_RAND_GAP_EN
      g = int'(lf[3:0] & 4'hF);
`else
      g = 15;
`endif
      lf = {lf[0] ^ lf[2] ^ lf[3] ^ lf[5], lf[15:1]};
      c  = c + 1 + g;
    end
    wait_done("t6", 120);
    chk("t6_done_cyc", done_cyc, lastc + 1);

    go(2'd0, 8'd0, 8'd1, 16'd3, 4'hF, 1'b0, c0);
    push(8'd0, 1'b0, c0 + 1);
    push(8'd1, 1'b0, c0 + 17);
    push(8'd2, 1'b1, c0 + 33);
    wait_done("t6b", 80);
    chk("t6b_done_cyc", done_cyc, c0 + 34);

    repeat (3) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_src_gen.md
# stream_src_gen

Parametrised valid/ready stimulus source for bubble and back-pressure testing. Generates a bounded burst of data beats with a selectable data pattern and a programmable idle gap (bubble) after every accepted beat. Sits at the upstream end of pipeline-under-test benches and drives the DUT's input handshake. Replaces the free-running always-valid incrementing source.

## Interface
- WIDTH, 32, data width (>= 2)
- CNT_W, 16, width of beat counter and n_beats
- GAP_W, 4, width of gap length field
- SEED, 16'hACE1, LFSR seed (nonzero; used only with STREAM_SRC_RAND_GAP_EN)

- clk  in  1  clock
- rst_n  in  1  reset rst_n, asynchronous, active-low; clock clk
- start  in  1  1-cycle request; sampled only in IDLE
- mode  in  2  data pattern, latched on start
- base  in  WIDTH  first data value, latched on start
- step  in  WIDTH  increment for mode 0, latched on start
- n_beats  in  CNT_W  beats in burst, latched on start
- gap_len  in  GAP_W  idle cycles after each accepted beat, latched on start
- rand_en  in  1  randomise gap (macro only), latched on start
- data_o  out  WIDTH  beat data
- vld_o  out  1  beat valid
- rdy_i  in  1  downstream ready
- last_o  out  1  marks final beat of burst
- busy  out  1  state != IDLE
- done  out  1  1-cycle pulse after final beat accepted

## Operation
- States: IDLE, SEND, GAP.
- IDLE: vld_o=0. start=1 latches config, beat_cnt=0, data_o=base. If n_beats==0: done pulses next cycle, stay IDLE. Else -> SEND.
- SEND: vld_o=1. Handshake = vld_o & rdy_i. On handshake: beat_cnt+1, data_o advances per mode.
  - beat_cnt==n_beats-1 at handshake -> IDLE, done=1 next cycle.
  - else gap_eff>0 -> GAP, gap_cnt=gap_eff; else stay SEND (back-to-back beats).
- GAP: vld_o=0; gap_cnt decrements each cycle; at gap_cnt==1 -> SEND.
- Data patterns (all arithmetic mod 2^WIDTH):
  - mode 0: data += step.
  - mode 1: rotate left by 1 (walking bit from base).
  - mode 2: constant base.
  - mode 3: data -= step.
- last_o = vld_o & (beat_cnt == n_beats-1).
- While vld_o=1 and rdy_i=0: data_o, last_o, vld_o held stable (no drop, no change).
- start while busy ignored; config input changes while busy ignored.
- gap_eff = gap_len unless randomised (see Configuration).

## Timing
- Reset: state=IDLE, data_o=0, vld_o=0, last_o=0, busy=0, done=0, beat_cnt=0, gap_cnt=0, LFSR=SEED.
- start at edge T -> vld_o=1, data_o=base at T+1 (1-cycle latency); busy=1 at T+1.
- Accepted beat at edge T: next beat valid at T+1+gap_eff.
- Final handshake at edge T: vld_o=0, busy=0, done=1 during cycle T+1; done clears at T+2.
- n_beats==0: done pulse at T+1, busy stays 0.
- n_beats=2^CNT_W-1 max; beat_cnt never wraps.
- Async reset mid-burst: all outputs to reset values immediately; no done.
- All outputs registered; no combinational path rdy_i -> vld_o/data_o.

## Configuration
- Macro STREAM_SRC_RAND_GAP_EN.
- Defined: 16-bit Fibonacci LFSR, taps 16,14,13,11, seeded SEED at reset; advances once per handshake. With rand_en=1, gap_eff = lfsr[GAP_W-1:0] & gap_len (uses LFSR value before advance). rand_en=0 -> gap_eff=gap_len.
- Undefined: no LFSR; rand_en ignored; gap_eff=gap_len always. SEED unused.

## Test plan
- mode 0, base=5, step=3, n_beats=4, gap_len=0, rdy_i=1 -> data 5,8,11,14 on 4 consecutive cycles, last_o on 14, done pulse cycle after.
- mode 0, base=0, step=1, n_beats=3, gap_len=2, rdy_i=1 -> vld_o pattern 1,0,0,1,0,0,1; data 0,1,2.
- rdy_i low for 5 cycles on beat 2 of mode 1, base=1, WIDTH=8 -> data_o=8'h02 and vld_o held stable 5 cycles; mode 1 wrap 8'h80 -> 8'h01.
- n_beats=0 start -> no vld_o, done=1 one cycle after start, busy stays 0; start during busy -> ignored, burst count unchanged.
- rst_n asserted after beat 2 of 6 -> vld_o, busy, data_o go 0 immediately; no done; new start runs full 6 beats from base.
- Macro on, gap_len=4'hF, rand_en=1, SEED=16'hACE1 -> gaps match reference LFSR model; rand_en=0 -> gaps fixed 15.
